// File: rtl/alu4_pkg.sv
// Shared types and constants for the 4-bit ALU subsystem.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional flag outputs are controlled by ALU_FLAGS_EN.
package alu4_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu4_if.sv
// Operand/result bundle between the ALU and its producer/consumer.
// Latency: n/a (wiring only); the result side is driven from registers.
// Backpressure: none, valid-only strobes. ALU_FLAGS_EN adds carry_out/zero.
interface alu4_if #(
    parameter int WIDTH = alu4_pkg::ALU_W
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       ALU_CONT;
    logic [WIDTH-1:0] ALU_OUT;
    logic             out_valid;
`ifdef ALU_FLAGS_EN
    logic             carry_out;
    logic             zero;
`endif

    // Producer side: drives operands, observes results.
    modport master (
        output in_valid,
        output A,
        output B,
        output ALU_CONT,
        input  ALU_OUT,
        input  out_valid
`ifdef ALU_FLAGS_EN
        ,
        input  carry_out,
        input  zero
`endif
    );

    // ALU side: consumes operands, drives results.
    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  ALU_CONT,
        output ALU_OUT,
        output out_valid
`ifdef ALU_FLAGS_EN
        ,
        output carry_out,
        output zero
`endif
    );

endinterface

// File: rtl/alu4_adder_4bit.sv
// Combinational WIDTH-bit adder with carry-in/carry-out, shared by ADD and SUB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit on the left catches the carry out of the MSB.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu4_core.sv
// Registered ADD/SUB/AND/OR unit; ALU_FLAGS_EN adds registered carry_out and zero.
// Latency: 1 cycle from in_valid to out_valid, one op per cycle.
// Backpressure: none; with in_valid low the outputs hold and out_valid drops.
module alu4_core
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic  clk,
    input  logic  rst_n,
    alu4_if.slave bus
);

    alu_op_e          op;
    logic             sel_add;
    logic             sel_sub;
    logic             sel_and;
    logic             sel_or;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Decode the op select into one-hot unit selects; every code is legal.
    always_comb begin
        op      = alu_op_e'(bus.ALU_CONT);
        sel_add = 1'b0;
        sel_sub = 1'b0;
        sel_and = 1'b0;
        sel_or  = 1'b0;
        case (op)
            OP_ADD: sel_add = 1'b1;
            OP_SUB: sel_sub = 1'b1;
            OP_AND: sel_and = 1'b1;
            OP_OR:  sel_or  = 1'b1;
        endcase
    end

    // SUB reuses the adder as A + ~B + 1.
    assign add_b   = sel_sub ? ~bus.B : bus.B;
    assign add_cin = sel_sub;

    adder_4bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (bus.A),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // AND-OR mux: only the selected unit's value can reach the result.
    assign result = ({WIDTH{sel_add | sel_sub}} & add_sum)
                  | ({WIDTH{sel_and}}           & (bus.A & bus.B))
                  | ({WIDTH{sel_or}}            & (bus.A | bus.B));

    // Next-state: capture a new result on in_valid, otherwise hold it.
    always_comb begin
        alu_out_d   = alu_out_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            alu_out_d = result;
        end
    end

    // Result and strobe registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.ALU_OUT   = alu_out_q;
    assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
    logic carry_out_d;
    logic carry_out_q;
    logic zero_d;
    logic zero_q;

    // Flags follow the result register: carry only from the adder ops.
    always_comb begin
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        if (bus.in_valid) begin
            carry_out_d = (sel_add | sel_sub) & add_cout;
            zero_d      = (result == '0);
        end
    end

    // Flag registers share the result's timing and reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.carry_out = carry_out_q;
    assign bus.zero      = zero_q;
`else
    // Adder carry has no consumer without the flag outputs.
    logic unused_add_cout;
    assign unused_add_cout = add_cout;
`endif

endmodule

// File: tb/tb_alu4_core.sv
// Scoreboard bench for alu4_core: directed cases, async reset, hold, random sweep.
// Latency: expects each result exactly one cycle after its sample edge.
// Backpressure: none; flag checks are compiled in only with ALU_FLAGS_EN.
module tb_alu4_core;
    import alu4_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu4_if #(.WIDTH(ALU_W)) bus ();

    alu4_core #(
        .WIDTH (ALU_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic       z;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model from the arithmetic definitions of each op.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        e.c = 1'b0;
        case (op)
            0: begin
                r   = (a + b) % 16;
                e.c = ((a + b) >= 16);
            end
            1: begin
                r   = (a - b + 16) % 16;
                e.c = (a >= b);
            end
            2:       r = a & b;
            default: r = a | b;
        endcase
        e.res = 4'(r);
        e.z   = (r == 0);
        e.due = 0;
        return e;
    endfunction

    task automatic issue(input int a, input int b, input int op);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.A        = 4'(a);
        bus.B        = 4'(b);
        bus.ALU_CONT = 2'(op);
        e     = model(a, b, op);
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Idle cycle with scrambled operands to prove they are ignored.
    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 4'($urandom_range(0, 15));
        bus.B        = 4'($urandom_range(0, 15));
        bus.ALU_CONT = 2'($urandom_range(0, 3));
    endtask

    // Monitor: pops on out_valid, otherwise verifies reset values or hold.
    logic [3:0] hold_out = '0;
    logic       hold_c   = 1'b0;
    logic       hold_z   = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_alu_out", 32'(bus.ALU_OUT), 32'd0);
            check("reset_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef ALU_FLAGS_EN
            check("reset_carry", 32'(bus.carry_out), 32'd0);
            check("reset_zero", 32'(bus.zero), 32'd0);
`endif
            hold_out = '0;
            hold_c   = 1'b0;
            hold_z   = 1'b0;
        end else if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("alu_out", 32'(bus.ALU_OUT), 32'(mon_e.res));
                check("latency_cycle", 32'(cyc), 32'(mon_e.due));
`ifdef ALU_FLAGS_EN
                check("carry_out", 32'(bus.carry_out), 32'(mon_e.c));
                check("zero", 32'(bus.zero), 32'(mon_e.z));
`endif
                hold_out = mon_e.res;
                hold_c   = mon_e.c;
                hold_z   = mon_e.z;
            end
        end else begin
            check("out_valid_low", 32'(bus.out_valid), 32'd0);
            check("hold_alu_out", 32'(bus.ALU_OUT), 32'(hold_out));
`ifdef ALU_FLAGS_EN
            check("hold_carry", 32'(bus.carry_out), 32'(hold_c));
            check("hold_zero", 32'(bus.zero), 32'(hold_z));
`endif
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.ALU_CONT = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD, including wrap to zero with carry.
        issue(5, 3, 0);
        issue(15, 1, 0);
        // SUB with and without borrow.
        issue(5, 3, 1);
        issue(3, 5, 1);
        // Logic ops back to back.
        issue(12, 10, 2);
        issue(12, 10, 3);
        // Hold for three cycles with changing inputs.
        repeat (3) idle();

        // Asynchronous reset mid-stream with in_valid high.
        issue(9, 4, 0);
        issue(7, 7, 3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_alu_out", 32'(bus.ALU_OUT), 32'd0);
        check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        check("reset_held_alu_out", 32'(bus.ALU_OUT), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // First op after release, then the random sweep over all ops.
        issue(6, 6, 1);
        for (int i = 0; i < 256; i++) begin
            for (int op = 0; op < 4; op++) begin
                if ($urandom_range(0, 7) == 0) idle();
                issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), op);
            end
        end
        repeat (4) idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu4_core.md
# alu4_core

Registered 4-bit, four-operation arithmetic/logic unit. Each cycle it takes operands `A` and `B` and a 2-bit op select `ALU_CONT`, and produces one result `ALU_OUT`. It is the top level of the small ALU subsystem and feeds downstream datapath registers. Inputs are sampled on a valid strobe, and the result is registered with fixed one-cycle latency.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width. Only 4 is verified.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: when high, `A`, `B` and `ALU_CONT` are sampled this edge.
- `A`, input, `WIDTH`: operand A, unsigned / two's complement.
- `B`, input, `WIDTH`: operand B.
- `ALU_CONT`, input, 2: op select. 00 = ADD, 01 = SUB, 10 = AND, 11 = OR.
- `ALU_OUT`, output, `WIDTH`: registered result.
- `out_valid`, output, 1: high for one cycle when `ALU_OUT` holds a new result.
- `carry_out`, output, 1: present only with `ALU_FLAGS_EN`.
- `zero`, output, 1: present only with `ALU_FLAGS_EN`.

## Operation
- ADD: `ALU_OUT = (A + B) mod 2^WIDTH`. Overflow wraps silently.
- SUB: `ALU_OUT = (A - B) mod 2^WIDTH`, two's complement. Implement as `A + ~B + 1` through the same adder.
- AND: bitwise `A & B`.
- OR: bitwise `A | B`.
- Op decode is a full case on `ALU_CONT`; all four codes are legal, with no default or X path.
- Result mux is one-hot from the decoded op. Only the selected unit's value reaches `ALU_OUT`; unselected units have no effect.
- When `in_valid` is low: `ALU_OUT` (and the flags, if enabled) hold their last value, and `out_valid` is 0 the next cycle.
- Operands are not otherwise checked; X-free inputs are required when `in_valid` is high.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on `ALU_OUT` after edge N, with `out_valid` = 1 in cycle N+1.
- Throughput: one operation per cycle. Back-to-back `in_valid` gives back-to-back `out_valid`.
- Reset, asynchronous on `rst_n` low: `ALU_OUT` = 0, `out_valid` = 0, `carry_out` = 0, `zero` = 0. These hold while `rst_n` is low.
- Reset mid-operation: any in-flight result is discarded.
- First sample after release: the first rising edge with `rst_n` high and `in_valid` high.
- No combinational path from inputs to outputs.

## Configuration
- Macro `ALU_FLAGS_EN`, defined:
  - `carry_out` and `zero` ports exist and are registered alongside `ALU_OUT`, with the same latency and reset.
  - `carry_out`: ADD gives the carry out of the MSB. SUB gives the adder carry out of `A + ~B + 1` (1 = no borrow, i.e. A ≥ B). AND and OR give 0.
  - `zero`: 1 when the next `ALU_OUT` is all zeros.
- Macro not defined: both flag ports and their registers are absent. `ALU_OUT` behaviour is unchanged.

## Structure
- Package `alu4_pkg` holds:
  - `alu_op_e`, a 2-bit enum: `OP_ADD` = 2'b00, `OP_SUB` = 2'b01, `OP_AND` = 2'b10, `OP_OR` = 2'b11.
  - `ALU_W` = 4.
- Sub-module `adder_4bit`: combinational `WIDTH`-bit adder with carry-in and carry-out, shared by ADD (cin = 0) and SUB (B inverted, cin = 1).
- AND, OR, op decode, result mux and output registers sit inline in `alu4_core`.

## Test plan
- Reset: assert `rst_n` = 0 asynchronously mid-stream with `in_valid` = 1. `ALU_OUT` = 0 and `out_valid` = 0 immediately, and stay so until release.
- ADD: A = 0101, B = 0011, op 00. Next cycle `ALU_OUT` = 1000, `out_valid` = 1. Then A = 1111, B = 0001 gives 0000, with `carry_out` = 1 and `zero` = 1 under the flag macro.
- SUB: A = 0101, B = 0011, op 01 gives 0010 (`carry_out` = 1). A = 0011, B = 0101 gives 1110 (`carry_out` = 0).
- Logic: A = 1100, B = 1010. Op 10 gives 1000; op 11 gives 1110. Ops applied on consecutive cycles give results on consecutive cycles.
- Hold: after a result, drop `in_valid` for 3 cycles while changing A, B and `ALU_CONT`. `ALU_OUT` is unchanged and `out_valid` = 0.
- Sweep: all 4 ops over 256 random A/B pairs checked against a reference model modulo 16. No mismatches, and latency is exactly 1 cycle.
